// File: rtl/uart_pkg.sv
// Shared types, sampling constants and majority vote for the 16x UART receiver.
// State PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_A   = 4'd7;
  localparam logic [3:0] SAMPLE_B   = 4'd8;
  localparam logic [3:0] SAMPLE_C   = 4'd9;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle level 1.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with valid/ready output and error pulses.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 baud_x16_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  rx_state_t              r_state;
  logic [3:0]             r_tcnt;
  logic [3:0]             r_bidx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_sa;
  logic                   r_sb;
  logic                   r_par_bad;
  logic                   r_par_err;
  logic                   w_rx_s;
  logic                   w_maj;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Third vote is the live sample at SAMPLE_C
  assign w_maj = maj3(r_sa, r_sb, w_rx_s);
  assign busy  = (r_state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  assign parity_err = r_par_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_sa        <= 1'b1;
      r_sb        <= 1'b1;
      r_par_bad   <= 1'b0;
      r_par_err   <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      r_par_err   <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (!en) begin
        r_state <= S_IDLE;
        r_tcnt  <= '0;
      end else if (baud_x16_tick) begin
        if (r_state != S_IDLE) r_tcnt <= r_tcnt + 4'd1;
        if (r_tcnt == SAMPLE_A) r_sa <= w_rx_s;
        if (r_tcnt == SAMPLE_B) r_sb <= w_rx_s;

        case (r_state)
          S_IDLE: begin
            if (!w_rx_s) begin
              r_state   <= S_START;
              r_tcnt    <= '0;
              r_par_bad <= 1'b0;
            end
          end
          S_START: begin
            if (r_tcnt == SAMPLE_C && w_maj) begin
              r_state <= S_IDLE;
              r_tcnt  <= '0;
            end else if (r_tcnt == LAST_TICK) begin
              r_state <= S_DATA;
              r_bidx  <= '0;
            end
          end
          S_DATA: begin
            if (r_tcnt == SAMPLE_C) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_tcnt == LAST_TICK) begin
              if (r_bidx == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end else begin
                r_bidx <= r_bidx + 4'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (r_tcnt == SAMPLE_C && (w_maj != ((^r_shift) ^ PAR_ODD))) begin
              r_par_err <= 1'b1;
              r_par_bad <= 1'b1;
            end
            if (r_tcnt == LAST_TICK) r_state <= S_STOP;
          end
`endif
          S_STOP: begin
            if (r_tcnt == SAMPLE_C) begin
              if (w_maj) begin
                // Leave at mid-stop so the next start edge is never missed
                r_state <= S_IDLE;
                r_tcnt  <= '0;
                if (!r_par_bad) begin
                  if (!m_valid || m_ready) begin
                    m_data  <= r_shift;
                    m_valid <= 1'b1;
                  end else begin
                    overrun_err <= 1'b1;
                  end
                end
              end else begin
                frame_err <= 1'b1;
                r_state   <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_tcnt  <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built from bit lists, the expected
// deliveries and error pulse counts come from a frame-level receive model.
module tb_uart_rx;

  localparam int DB      = 8;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
`else
  localparam bit PAR_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          rx = 1'b1;
  logic          m_ready = 1'b1;
  logic [DB-1:0] m_data;
  logic          m_valid, busy, frame_err, overrun_err, parity_err;
  logic [1:0]    tcnt_tb = 2'd0;
  logic          tick;

  int n_cmp = 0, n_fail = 0;
  int frame_exp = 0, ovr_exp = 0, par_exp = 0;
  int frame_obs = 0, ovr_obs = 0, par_obs = 0;
  logic [DB-1:0] exp_q[$];
  bit model_full = 1'b0;
  bit prev_hold = 1'b0;
  logic [DB-1:0] prev_data = '0;

  uart_rx #(.DATA_BITS(DB), .SYNC_STAGES(2), .PARITY_ODD(int'(PAR_ODD))) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .baud_x16_tick (tick),
    .rx            (rx),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcnt_tb <= tcnt_tb + 2'd1;
  assign tick = (tcnt_tb == 2'd3);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and counts error pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_err)   frame_obs++;
      if (overrun_err) ovr_obs++;
      if (parity_err)  par_obs++;
      if (prev_hold && m_valid) chk("m_data_stable", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_delivery: got %0h, required no delivery", m_data);
        end else begin
          chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic align_tick();
    do begin @(posedge clk); #1; end while (tcnt_tb != 2'd0);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level expectation: what the receiver must do with one complete frame
  task automatic model_frame(input logic [DB-1:0] d, input logic stop_bit,
                             input logic par_flip, input logic rdy_pulse);
    bit pbad;
    pbad = par_flip && PAR_EN;
    if (pbad) par_exp++;
    if (!stop_bit) frame_exp++;
    else if (!pbad) begin
      if (model_full && !(rdy_pulse || m_ready)) ovr_exp++;
      else begin
        exp_q.push_back(d);
        model_full = !m_ready;
      end
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                            input logic par_flip, input logic rdy_pulse);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back((^d) ^ PAR_ODD ^ par_flip);
    bits.push_back(stop_bit);
    model_frame(d, stop_bit, par_flip, rdy_pulse);
    align_tick();
    for (int j = 0; j < bits.size(); j++) begin
      rx = bits[j];
      if (rdy_pulse && j == bits.size() - 1) begin
        // m_ready high exactly in the stop-bit evaluation cycle (tick 44 of the bit)
        wait_clk(43);
        m_ready = 1'b1;
        wait_clk(1);
        m_ready = 1'b0;
        wait_clk(20);
      end else begin
        wait_clk(64);
      end
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_err"},   32'(frame_obs), 32'(frame_exp));
    chk({tag, "_overrun_err"}, 32'(ovr_obs),   32'(ovr_exp));
    chk({tag, "_parity_err"},  32'(par_obs),   32'(par_exp));
    chk({tag, "_pending"},     32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    wait_clk(5);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_errs",    32'({frame_err, overrun_err, parity_err}), 32'd0);
    rst_n = 1'b1;
    wait_clk(20);

    // Baseline byte
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    chk("t1_busy", 32'(busy), 32'd0);
    check_counts("t1");

    // Short glitch, then a real frame
    align_tick();
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(100);
    chk("t2_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    check_counts("t2");

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_clk(160);
    chk("t3_busy_break", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_clk(40);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    check_counts("t3");

    // Overrun with the consumer stalled
    m_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    wait_clk(10);
    chk("t4_m_valid_held", 32'(m_valid), 32'd1);
    chk("t4_m_data_held",  32'(m_data),  32'h11);
    m_ready = 1'b1;
    wait_clk(1);
    m_ready = 1'b0;
    model_full = 1'b0;
    chk("t4_m_valid_drop", 32'(m_valid), 32'd0);
    check_counts("t4");

    // Accept in the very cycle a new byte is delivered
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    wait_clk(5);
    chk("t5_m_valid", 32'(m_valid), 32'd1);
    chk("t5_m_data",  32'(m_data),  32'h22);
    m_ready = 1'b1;
    model_full = 1'b0;
    wait_clk(5);
    check_counts("t5");

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      wait_clk(20);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      wait_clk(20);
      check_counts("t6_parity");
    end

    // Receiver disabled mid-frame
    align_tick();
    rx = 1'b0;
    wait_clk(100);
    chk("en_busy_before", 32'(busy), 32'd1);
    en = 1'b0;
    wait_clk(1);
    chk("en_busy_after", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_clk(80);
    en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    check_counts("en");

    // Reset mid-frame with a byte still held
    m_ready = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    align_tick();
    rx = 1'b0;
    wait_clk(200);
    chk("rst2_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst2_m_valid", 32'(m_valid), 32'd0);
    chk("rst2_m_data",  32'(m_data),  32'd0);
    chk("rst2_busy",    32'(busy),    32'd0);
    chk("rst2_errs",    32'({frame_err, overrun_err, parity_err}), 32'd0);
    exp_q.delete();
    model_full = 1'b0;
    rx = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    m_ready = 1'b1;
    wait_clk(10);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    wait_clk(20);
    check_counts("rst2");

    // Random frames with occasional framing and parity faults
    for (int k = 0; k < 24; k++) begin
      logic [DB-1:0] d;
      logic sb, pf;
      d  = DB'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 4) == 0);
      send_frame(d, sb, pf, 1'b0);
      rx = 1'b1;
      wait_clk($urandom_range(16, 80));
    end
    wait_clk(20);
    check_counts("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
